fen_src_arbiter: RTL and testbench

FEN_SRC_ARBITER -- requirements
Module: fen_src_arbiter

---
 rtl/fen_pkg.sv | 14 +
 rtl/fen_rr_arb2.sv | 38 +++
 rtl/fen_src_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fen_src_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fen_pkg.sv
// Shared definitions for the FEN source arbiter.
//   FenByteW    - width of one ASCII FEN byte on every stream
//   arb_state_e - arbiter FSM state encoding
package fen_pkg;

  localparam int unsigned FenByteW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StWaitPos
  } arb_state_e;

endpackage

// File: rtl/fen_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer register.
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_i[1:0]   - request per source
//   en_i         - arbitration allowed this cycle (pointer only moves on a grant)
//   gnt_valid_o  - a grant is issued this cycle
//   gnt_id_o     - index of the granted source
module fen_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_valid_o = en_i & (|req_i);
    // On a tie the source not granted last wins; otherwise the lone requester.
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_q;
    end else begin
      gnt_id_o = req_i[1];
    end
    last_d = gnt_valid_o ? gnt_id_o : last_q;
  end

  // Pointer resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fen_src_arbiter.sv
// Arbitrates two FEN byte sources (host link, UART) onto one FEN decoder.
// A granted packet is forwarded with one register stage; after its last byte the
// arbiter holds the decoder until the decoder reports the end of its square stream
// (or a timeout expires), then returns to arbitration.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   s0_*/s1_* data/valid/sop/eop    - source beats; s*_ready accepts a beat
//   dec_data/valid/sop/eop          - registered beat stream to the decoder
//   dec_pos_valid, dec_pos_eop      - decoder square-stream qualifiers
//   grant_id                        - source owning the decoder
//   busy                            - arbiter not idle
//   pkt_done, err_timeout           - one-cycle completion / timeout pulses
//   drop_count                      - saturating count of stray beats discarded while idle
module fen_src_arbiter
  import fen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DROP_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FenByteW-1:0] s0_data,
  input  logic                s0_valid,
  input  logic                s0_sop,
  input  logic                s0_eop,
  output logic                s0_ready,
  input  logic [FenByteW-1:0] s1_data,
  input  logic                s1_valid,
  input  logic                s1_sop,
  input  logic                s1_eop,
  output logic                s1_ready,
  output logic [FenByteW-1:0] dec_data,
  output logic                dec_valid,
  output logic                dec_sop,
  output logic                dec_eop,
  input  logic                dec_pos_valid,
  input  logic                dec_pos_eop,
  output logic                grant_id,
  output logic                busy,
  output logic                pkt_done,
  output logic                err_timeout,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic                grant_id_q, grant_id_d;
  logic [FenByteW-1:0] dec_data_q, dec_data_d;
  logic                dec_valid_q, dec_valid_d;
  logic                dec_sop_q, dec_sop_d;
  logic                dec_eop_q, dec_eop_d;
  logic                pkt_done_q, pkt_done_d;
  logic                err_timeout_q, err_timeout_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                rdy0, rdy1;
  logic                stray0, stray1;
  logic [DROP_W:0]     drop_sum;
  logic                arb_gnt_valid, arb_gnt_id;
  logic                sel_valid, sel_sop, sel_eop;
  logic [FenByteW-1:0] sel_data;

  assign stray0 = s0_valid & ~s0_sop;
  assign stray1 = s1_valid & ~s1_sop;

  fen_rr_arb2 u_rr_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({s1_valid & s1_sop, s0_valid & s0_sop}),
    .en_i        (state_q == StIdle),
    .gnt_valid_o (arb_gnt_valid),
    .gnt_id_o    (arb_gnt_id)
  );

  // Beat from the source currently owning the decoder.
  always_comb begin
    if (grant_id_q) begin
      sel_valid = s1_valid;
      sel_sop   = s1_sop;
      sel_eop   = s1_eop;
      sel_data  = s1_data;
    end else begin
      sel_valid = s0_valid;
      sel_sop   = s0_sop;
      sel_eop   = s0_eop;
      sel_data  = s0_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    dec_data_d    = dec_data_q;
    dec_valid_d   = 1'b0;
    dec_sop_d     = 1'b0;
    dec_eop_d     = 1'b0;
    pkt_done_d    = 1'b0;
    err_timeout_d = 1'b0;
    drop_count_d  = drop_count_q;
    timer_d       = '0;
    rdy0          = 1'b0;
    rdy1          = 1'b0;
    // Wide sum so a carry out means the counter must saturate.
    drop_sum      = {1'b0, drop_count_q} + {{DROP_W{1'b0}}, stray0}
                    + {{DROP_W{1'b0}}, stray1};

    case (state_q)
      StIdle: begin
        // Non-sop beats are swallowed; sop beats wait for the grant.
        rdy0 = stray0;
        rdy1 = stray1;
        drop_count_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        if (arb_gnt_valid) begin
          grant_id_d = arb_gnt_id;
          state_d    = StFwd;
        end
      end
      StFwd: begin
        rdy0 = ~grant_id_q;
        rdy1 = grant_id_q;
        if (sel_valid) begin
          dec_valid_d = 1'b1;
          dec_sop_d   = sel_sop;
          dec_eop_d   = sel_eop;
          dec_data_d  = sel_data;
          if (sel_eop) begin
            state_d = StWaitPos;
          end
        end
      end
      StWaitPos: begin
        timer_d = timer_q + 1'b1;
        // Decoder completion takes priority over a timeout in the same cycle.
        if (dec_pos_valid && dec_pos_eop) begin
          pkt_done_d = 1'b1;
          state_d    = StIdle;
          timer_d    = '0;
        end else if (timer_q == TimerLast) begin
          err_timeout_d = 1'b1;
          state_d       = StIdle;
          timer_d       = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_id_q    <= 1'b0;
      dec_data_q    <= '0;
      dec_valid_q   <= 1'b0;
      dec_sop_q     <= 1'b0;
      dec_eop_q     <= 1'b0;
      pkt_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      drop_count_q  <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      dec_data_q    <= dec_data_d;
      dec_valid_q   <= dec_valid_d;
      dec_sop_q     <= dec_sop_d;
      dec_eop_q     <= dec_eop_d;
      pkt_done_q    <= pkt_done_d;
      err_timeout_q <= err_timeout_d;
      drop_count_q  <= drop_count_d;
      timer_q       <= timer_d;
    end
  end

  // Readies are combinational from idle state, so mask them while reset is held.
  assign s0_ready    = rdy0 & rst_n;
  assign s1_ready    = rdy1 & rst_n;
  assign dec_data    = dec_data_q;
  assign dec_valid   = dec_valid_q;
  assign dec_sop     = dec_sop_q;
  assign dec_eop     = dec_eop_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != StIdle);
  assign pkt_done    = pkt_done_q;
  assign err_timeout = err_timeout_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_fen_src_arbiter.sv
// Scoreboard bench for fen_src_arbiter: stimulus pushes expected decoder beats,
// a monitor pops and compares them, a decoder responder checks completion/timeouts.
module tb_fen_src_arbiter;

  localparam int unsigned To = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0;
  logic       s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] dec_data;
  logic       dec_valid, dec_sop, dec_eop;
  logic       dec_pos_valid = 1'b0, dec_pos_eop = 1'b0;
  logic       grant_id, busy, pkt_done, err_timeout;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  fen_src_arbiter #(
    .TIMEOUT_CYCLES (To),
    .DROP_W         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s0_data       (s0_data),
    .s0_valid      (s0_valid),
    .s0_sop        (s0_sop),
    .s0_eop        (s0_eop),
    .s0_ready      (s0_ready),
    .s1_data       (s1_data),
    .s1_valid      (s1_valid),
    .s1_sop        (s1_sop),
    .s1_eop        (s1_eop),
    .s1_ready      (s1_ready),
    .dec_data      (dec_data),
    .dec_valid     (dec_valid),
    .dec_sop       (dec_sop),
    .dec_eop       (dec_eop),
    .dec_pos_valid (dec_pos_valid),
    .dec_pos_eop   (dec_pos_eop),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .err_timeout   (err_timeout),
    .drop_count    (drop_count)
  );

  typedef struct packed {logic sop; logic eop; logic [7:0] d;} beat_t;
  typedef beat_t pkt_t[$];
  typedef struct packed {logic id; logic sop; logic eop; logic [7:0] d;} exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_last = 1;    // model: last granted source
  int   m_drop = 0;    // model: dropped-beat count
  int   resp_mode = 0; // 0 random reply, 1 never reply, 2 reply on last timer cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic sop, input logic eop,
                         input logic [7:0] d);
    if (src == 0) begin
      s0_valid = v; s0_sop = sop; s0_eop = eop; s0_data = d;
    end else begin
      s1_valid = v; s1_sop = sop; s1_eop = eop; s1_data = d;
    end
  endtask

  function automatic logic get_ready(input int src);
    return (src == 0) ? s0_ready : s1_ready;
  endfunction

  function automatic pkt_t rand_pkt(input int len);
    pkt_t p;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d   = 8'($urandom_range(32, 126));
      b.sop = (i == 0) || (i > 0 && i < len - 1 && ($urandom % 5) == 0);
      b.eop = (i == len - 1);
      p.push_back(b);
    end
    return p;
  endfunction

  function automatic pkt_t str_pkt(input string s, input logic framed);
    pkt_t p;
    for (int i = 0; i < s.len(); i++) begin
      beat_t b;
      b.d   = s[i];
      b.sop = framed && (i == 0);
      b.eop = framed && (i == s.len() - 1);
      p.push_back(b);
    end
    return p;
  endfunction

  task automatic push_exp(input int src, input pkt_t p, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.id = src[0]; e.sop = p[i].sop; e.eop = p[i].eop; e.d = p[i].d;
      exp_q.push_back(e);
    end
    m_last = src;
  endtask

  // Drives n beats of p on a source, starting at posedge+1; returns at posedge+1.
  task automatic send(input int src, input pkt_t p, input int n, input logic stray);
    int w;
    for (int i = 0; i < n; i++) begin
      set_src(src, 1'b1, p[i].sop, p[i].eop, p[i].d);
      w = 0;
      @(negedge clk);
      while (!get_ready(src) && w < 3000) begin
        w++;
        @(negedge clk);
      end
      if (!get_ready(src)) begin
        chk("ready_wait", 32'(get_ready(src)), 32'd1);
        set_src(src, 1'b0, 1'b0, 1'b0, 8'h00);
        return;
      end
      @(posedge clk);
      #1;
      if (stray) begin
        chk("stray_not_fwd", 32'(dec_valid), 32'd0);
      end else begin
        chk("dec_latency_valid", 32'(dec_valid), 32'd1);
        chk("dec_latency_data", 32'(dec_data), 32'(p[i].d));
      end
      if (($urandom % 4) == 0) begin
        set_src(src, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    set_src(src, 1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && w < 3000) begin
      w++;
      @(negedge clk);
    end
    if (busy || exp_q.size() != 0) begin
      chk("idle_wait_busy", 32'(busy), 32'd0);
      chk("idle_wait_pending", 32'(exp_q.size()), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // mask bit0: s0 sends p0, bit1: s1 sends p1, both starting the same cycle.
  task automatic run_pkts(input int mask, input pkt_t p0, input pkt_t p1);
    if (mask == 3) begin
      if (m_last == 1) begin
        push_exp(0, p0, p0.size()); push_exp(1, p1, p1.size());
      end else begin
        push_exp(1, p1, p1.size()); push_exp(0, p0, p0.size());
      end
    end else if (mask == 1) begin
      push_exp(0, p0, p0.size());
    end else begin
      push_exp(1, p1, p1.size());
    end
    fork
      if (mask[0]) send(0, p0, p0.size(), 1'b0);
      if (mask[1]) send(1, p1, p1.size(), 1'b0);
    join
    wait_idle();
  endtask

  task automatic run_strays(input int n0, input int n1);
    pkt_t p0 = rand_pkt(n0 > 0 ? n0 : 1);
    pkt_t p1 = rand_pkt(n1 > 0 ? n1 : 1);
    for (int i = 0; i < p0.size(); i++) begin p0[i].sop = 1'b0; p0[i].eop = 1'b0; end
    for (int i = 0; i < p1.size(); i++) begin p1[i].sop = 1'b0; p1[i].eop = 1'b0; end
    m_drop = (m_drop + n0 + n1 > 255) ? 255 : m_drop + n0 + n1;
    fork
      if (n0 > 0) send(0, p0, n0, 1'b1);
      if (n1 > 0) send(1, p1, n1, 1'b1);
    join
    @(negedge clk);
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("stray_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(s1_ready), 32'd0);
    chk("rst_dec", 32'({dec_valid, dec_sop, dec_eop, dec_data}), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({pkt_done, err_timeout}), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
  endtask

  // Monitor: every decoder beat must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && dec_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dec_unexpected: got beat 0x%0h, required no beat at %0t",
                 dec_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("dec_beat", 32'({grant_id, dec_sop, dec_eop, dec_data}), 32'(e));
      end
    end
  end

  // Decoder responder: answers each dec_eop and checks completion / timeout pulses.
  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && dec_valid && dec_eop) begin
        if (resp_mode == 1) begin
          repeat (To - 1) @(posedge clk);
          @(negedge clk);
          chk("timeout_not_early", 32'(err_timeout), 32'd0);
          chk("timeout_still_busy", 32'(busy), 32'd1);
          @(negedge clk);
          chk("timeout_pulse", 32'(err_timeout), 32'd1);
          chk("timeout_idle", 32'(busy), 32'd0);
          chk("timeout_no_done", 32'(pkt_done), 32'd0);
          @(negedge clk);
          chk("timeout_one_cycle", 32'(err_timeout), 32'd0);
        end else begin
          d = (resp_mode == 2) ? To - 2 : $urandom_range(0, 5);
          repeat (d + 1) @(posedge clk);
          #1;
          dec_pos_valid = 1'b1;
          dec_pos_eop   = 1'b1;
          @(posedge clk);
          #1;
          dec_pos_valid = 1'b0;
          dec_pos_eop   = 1'b0;
          @(negedge clk);
          chk("pkt_done_pulse", 32'(pkt_done), 32'd1);
          chk("pkt_done_no_err", 32'(err_timeout), 32'd0);
          chk("pkt_done_idle", 32'(busy), 32'd0);
          @(negedge clk);
          chk("pkt_done_one_cycle", 32'(pkt_done), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : main
    pkt_t pa, pb, part;
    int   mask;

    // Reset values, including ready masking of a stray beat during reset.
    s1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    s1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests after reset: s0 first, then s1; next tie goes to s0 again.
    run_pkts(3, rand_pkt(5), rand_pkt(4));
    run_pkts(3, rand_pkt(3), rand_pkt(6));

    // Stray beats "abc" on s1 while idle.
    m_drop = 3;
    pa = str_pkt("abc", 1'b0);
    send(1, pa, 3, 1'b1);
    @(negedge clk);
    chk("drop_abc", 32'(drop_count), 32'd3);
    @(posedge clk);
    #1;

    // Full FEN string on s0 alone.
    pa = str_pkt("8/8/8/8/8/8/8/8 w - - 0 1", 1'b1);
    run_pkts(1, pa, pa);

    // Single-beat packet on s1.
    pb = rand_pkt(1);
    run_pkts(2, pb, pb);

    // Decoder never answers, then answers on the last timer cycle.
    resp_mode = 1;
    run_pkts(1, rand_pkt(4), pb);
    resp_mode = 2;
    run_pkts(2, pb, rand_pkt(3));
    resp_mode = 0;

    // Randomized mix of packets and stray beats.
    for (int k = 0; k < 40; k++) begin
      mask = $urandom_range(0, 3);
      if (mask == 0) begin
        run_strays($urandom_range(0, 3), $urandom_range(1, 3));
      end else begin
        run_pkts(mask, rand_pkt($urandom_range(1, 12)), rand_pkt($urandom_range(1, 12)));
      end
    end

    // Drop counter saturation with both sources dropping together.
    run_strays(130, 130);

    // Reset in the middle of a forwarded packet.
    run_pkts(2, pb, rand_pkt(2));
    part = rand_pkt(10);
    push_exp(0, part, 4);
    send(0, part, 4, 1'b0);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    s0_valid = 1'b1;
    s0_sop   = 1'b0;
    #1;
    chk_reset_outputs();
    chk("rst_pending_beats", 32'(exp_q.size()), 32'd0);
    m_last = 1;
    m_drop = 0;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    s0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_pkts(3, rand_pkt(6), rand_pkt(2));
    run_strays(1, 1);

    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
